period_meter: RTL

Measures the period and high time of a slow, asynchronous square wave, such as a divided clock, an external tick or a sensor pulse train. Results are expressed in cycles of the system clock. The block synchronises the input, detects its edges and counts clk cycles between successive rising edges. Each completed measurement is published with a one-cycle valid strobe, so downstream logic (display, UART report, self-check of divider outputs) can read it.

---
 rtl/period_meter_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 41 ++++
 rtl/period_meter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/period_meter_pkg.sv
// Shared types and helpers for the period meter and its input synchroniser.
//   state_t            : measurement FSM states
//   legal_sync_stages  : clamps a requested synchroniser depth into 2..4
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Depths outside the supported range are pulled to the nearest legal value.
    function automatic int unsigned legal_sync_stages(input int unsigned n);
        if (n < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end
        if (n > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end
        return n;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with registered edge detection for an async input.
//   clk, reset_n : clock and async active-low reset
//   async_in     : asynchronous input level
//   sync_out     : synchronised level (last synchroniser stage)
//   rise, fall   : one-cycle pulses, SYNC_STAGES+1 clk edges after the input edge
module sync_edge_det
    import period_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    localparam int unsigned STAGES = legal_sync_stages(SYNC_STAGES);

    logic [STAGES-1:0] chain;
    logic              hist;

    // Synchroniser chain, one history flop, and edge pulses from sync vs. history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            hist  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
            hist  <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~hist;
            fall  <= ~chain[STAGES-1] & hist;
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
//   clk, reset_n : clock and async active-low reset
//   enable       : measurement enable (synchronous)
//   sig_in       : signal under measurement (asynchronous)
//   period_out   : clk cycles between successive rising edges
//   high_out     : clk cycles from rising edge to following falling edge
//   valid        : one-cycle strobe, results updated
//   timeout      : one-cycle strobe, no rising edge within MAX_PERIOD cycles
//   no_signal    : sticky, set with timeout, cleared by valid or enable low
//   busy         : FSM is in ARM or MEASURE
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned MAX_PERIOD  = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = $clog2(MAX_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             valid,
    output logic             timeout,
    output logic             no_signal,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MAX_PERIOD);
    // ARM starts counting from 0, so its MAX_PERIOD-th idle cycle sees MAX_PERIOD-1.
    localparam logic [WIDTH-1:0] ARM_LIMIT = WIDTH'(MAX_PERIOD - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic sync_unused;
    logic rise;
    logic fall;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(sig_in),
        .sync_out(sync_unused),
        .rise    (rise),
        .fall    (fall)
    );

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] high_latch_q, high_latch_d;
    logic [WIDTH-1:0] period_d, high_d;
    logic             valid_d, timeout_d, no_signal_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        high_latch_d = high_latch_q;
        period_d     = period_out;
        high_d       = high_out;
        valid_d      = 1'b0;
        timeout_d    = 1'b0;
        no_signal_d  = no_signal;

        if (!enable) begin
            // Enable low overrides everything, including a coincident rise.
            state_d     = IDLE;
            count_d     = '0;
            no_signal_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    count_d = '0;
                end
                ARM: begin
                    if (rise) begin
                        state_d = MEASURE;
                        count_d = ONE;
                    end else if (count_q == ARM_LIMIT) begin
                        timeout_d   = 1'b1;
                        no_signal_d = 1'b1;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // A rise exactly at MAX_COUNT still yields a valid result.
                        period_d    = count_q;
                        high_d      = high_latch_q;
                        valid_d     = 1'b1;
                        no_signal_d = 1'b0;
                        count_d     = ONE;
                    end else if (count_q == MAX_COUNT) begin
                        timeout_d   = 1'b1;
                        no_signal_d = 1'b1;
                        state_d     = ARM;
                        count_d     = '0;
                    end else begin
                        count_d = count_q + ONE;
                        if (fall) begin
                            high_latch_d = count_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            high_latch_q <= '0;
            period_out   <= '0;
            high_out     <= '0;
            valid        <= 1'b0;
            timeout      <= 1'b0;
            no_signal    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            high_latch_q <= high_latch_d;
            period_out   <= period_d;
            high_out     <= high_d;
            valid        <= valid_d;
            timeout      <= timeout_d;
            no_signal    <= no_signal_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule
